uart_rx: RTL and testbench

- 8N1 UART receiver: deserialises the asynchronous serial line into bytes and presents them on a valid/ready byte interface.
- Sits at the serial pins of the serial_interface, opposite the team's UART transmitter.
- Oversamples at clk rate, samples each bit at mid-bit, and flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// default bit period used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  // 100 MHz clock / 115200 baud.
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input. RESET_VAL sets
// the value both flops take in reset so an idle-high line stays high.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first one a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronised, the start bit is qualified at
// its midpoint, and every following bit is sampled one bit period later.
//
// Byte interface: rx_valid rises with rx_data holding the received byte and
// stays high, with rx_data frozen, until a cycle where rx_valid & rx_ready;
// the byte is consumed on that edge. A byte finishing while an unaccepted byte
// is still held is dropped and reported with a one-cycle overrun pulse, unless
// the held byte is being accepted in that same cycle, in which case the new
// byte replaces it and rx_valid stays high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_uart,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy,
  output rx_state_e                 state_o
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                      rx_s;
  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      stop_ok, stop_bad;
  logic                      deliver_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_uart),
    .q_o   (rx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus bit-timing counters and the LSB-first shift register.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          // A line that is already high again at mid-start was a glitch.
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          // Leaving at mid stop bit leaves half a bit to catch the next start.
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers tracking the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Delivery one edge after the stop sample, byte hold and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      deliver_q   <= stop_ok;
      frame_err_q <= stop_bad;
      overrun_q   <= deliver_q && rx_valid_q && !rx_ready;
      if (deliver_q && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // Outputs: busy follows the FSM, everything else is registered.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    state_o   = state_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 16-clock bit period.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_uart;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  rx_state_e  state_o;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected bytes and bytes accepted over the handshake.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int cyc        = 0;
  int fe_cnt     = 0;
  int ov_cnt     = 0;
  int vcyc       = 0;
  int rise_cyc   = 0;
  logic prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_uart   (rx_uart),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .state_o   (state_o)
  );

  // Clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid) vcyc++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_uart = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic check_next(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({tag, "_present"}, (got_q.size() > 0), 1);
    if (got_q.size() > 0) chk({tag, "_data"}, got_q.pop_front(), e);
  endtask

  initial begin
    int t0, fe0, ov0, n0;
    rst_n    = 1'b0;
    rx_uart  = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (5) tick();

    // Basic receive of 0xA5.
    vcyc = 0; fe0 = fe_cnt; ov0 = ov_cnt;
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (8) tick();
    chk("basic_lat", ((rise_cyc - t0) >= 150 && (rise_cyc - t0) <= 160), 1);
    chk("basic_vcyc", vcyc, 1);
    chk("basic_ferr", fe_cnt - fe0, 0);
    chk("basic_ovr", ov_cnt - ov0, 0);
    check_next("basic");

    // False start: 4-cycle low glitch.
    vcyc = 0; fe0 = fe_cnt;
    rx_uart = 1'b0;
    repeat (4) tick();
    rx_uart = 1'b1;
    chk("glitch_busy_hi", busy, 1);
    repeat (8) tick();
    chk("glitch_busy_lo", busy, 0);
    repeat (20) tick();
    chk("glitch_novalid", vcyc, 0);
    chk("glitch_noferr", fe_cnt - fe0, 0);

    // Framing error, long break, then recovery.
    vcyc = 0; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx_uart = 1'b0;
    repeat (48) tick();
    chk("ferr_state", 32'(state_o), 32'(ST_BREAK));
    rx_uart = 1'b1;
    repeat (32) tick();
    chk("ferr_pulse", fe_cnt - fe0, 1);
    chk("ferr_novalid", vcyc, 0);
    chk("ferr_idle", busy, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (8) tick();
    check_next("recover");

    // Back-to-back frames without an idle gap.
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (8) tick();
    chk("b2b_count", got_q.size() - n0, 2);
    chk("b2b_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check_next("b2b_0");
    check_next("b2b_1");

    // Backpressure and overrun.
    rx_ready = 1'b0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (8) tick();
    chk("bp_valid", rx_valid, 1);
    chk("bp_data", rx_data, 8'h11);
    chk("bp_ovr", ov_cnt - ov0, 1);
    chk("bp_noferr", fe_cnt - fe0, 0);
    exp_q.push_back(8'h11);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("bp_drop", rx_valid, 0);
    check_next("bp_accept");
    rx_ready = 1'b1;

    // Asynchronous reset during bit 3 of 0xC3.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_uart = 1'b0;
    repeat (8) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_flags", {frame_err, overrun}, 0);
    rx_uart = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (32) tick();
    chk("post_rst_idle", busy, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (8) tick();
    check_next("post_rst");
    chk("leftover", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
